id_ex_stage: RTL and testbench

- Pipeline register between the instruction decoder (ID) and the execute stage (EX).
- Captures the decoder control bundle, register-file operands, the immediate and the instruction fields at each clock edge.
- Detects load-use hazards and inserts bubbles on load-use stall and on branch flush.
- Keeps wrapping bubble counters for performance debug.

---
 rtl/riscv_pkg.sv | 56 +++++
 rtl/hazard_detect.sv | 24 ++
 rtl/id_ex_stage.sv | 149 ++++++++++++++
 tb/tb_id_ex_stage.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 decode constants, control-bundle type and operand-use helpers
// for the ID/EX pipeline register and its hazard logic.
package riscv_pkg;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_S     = 7'b0100011;
   localparam logic [6:0] OP_B     = 7'b1100011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_SLL = 3'b010,
      ALU_SLT = 3'b011,
      ALU_XOR = 3'b100,
      ALU_SRL = 3'b101,
      ALU_OR  = 3'b110,
      ALU_AND = 3'b111
   } alu_op_e;

   typedef enum logic [1:0] {
      BR_NONE   = 2'd0,
      BR_BRANCH = 2'd1,
      BR_JAL    = 2'd2,
      BR_JALR   = 2'd3
   } br_ctrl_e;

   typedef struct packed {
      logic     RegWrite;
      logic     ALUsrc;
      logic     PCtoRegSrc;
      logic     RDsrc;
      logic     MRead;
      logic     MWrite;
      logic     MenToReg;
      alu_op_e  ALUop;
      br_ctrl_e branchCtrl;
   } ctrl_t;

   // A bubble must not write registers, touch memory or redirect the PC.
   localparam ctrl_t BUBBLE = '0;

   function automatic logic uses_rs1(input logic [6:0] op);
      return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
   endfunction

   function automatic logic uses_rs2(input logic [6:0] op);
      return (op == OP_R || op == OP_S || op == OP_B);
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard check: instruction in ID reads the register a load in EX
// is about to write. Purely combinational.
module hazard_detect
   import riscv_pkg::*;
(
   input  logic [6:0] id_op,
   input  logic       id_valid,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       ex_valid,
   input  logic       ex_MRead,
   input  logic [4:0] ex_rd,
   output logic       haz
);

   logic hit1, hit2;

   assign hit1 = uses_rs1(id_op) && (ex_rd == id_rs1);
   assign hit2 = uses_rs2(id_op) && (ex_rd == id_rs2);

   // x0 is never really written, so a load to x0 creates no dependency.
   assign haz = id_valid && ex_valid && ex_MRead && (ex_rd != 5'd0) && (hit1 || hit2);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall detection, bubble insertion on
// stall/flush, and wrapping bubble counters for performance debug.
module id_ex_stage
   import riscv_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             hold,
   input  logic             flush,
   input  logic             id_valid,
   input  logic [6:0]       id_op,
   input  logic             id_RegWrite,
   input  logic             id_ALUsrc,
   input  logic             id_PCtoRegSrc,
   input  logic             id_RDsrc,
   input  logic             id_MRead,
   input  logic             id_MWrite,
   input  logic             id_MenToReg,
   input  logic [2:0]       id_ALUop,
   input  logic [1:0]       id_branchCtrl,
   input  logic [XLEN-1:0]  id_pc,
   input  logic [XLEN-1:0]  id_rs1_data,
   input  logic [XLEN-1:0]  id_rs2_data,
   input  logic [XLEN-1:0]  id_imm,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic [4:0]       id_rd,
   input  logic [2:0]       id_funct3,
   input  logic [6:0]       id_funct7,
   output logic             ex_valid,
   output logic             ex_RegWrite,
   output logic             ex_ALUsrc,
   output logic             ex_PCtoRegSrc,
   output logic             ex_RDsrc,
   output logic             ex_MRead,
   output logic             ex_MWrite,
   output logic             ex_MenToReg,
   output logic [2:0]       ex_ALUop,
   output logic [1:0]       ex_branchCtrl,
   output logic [XLEN-1:0]  ex_pc,
   output logic [XLEN-1:0]  ex_rs1_data,
   output logic [XLEN-1:0]  ex_rs2_data,
   output logic [XLEN-1:0]  ex_imm,
   output logic [4:0]       ex_rs1,
   output logic [4:0]       ex_rs2,
   output logic [4:0]       ex_rd,
   output logic [2:0]       ex_funct3,
   output logic [6:0]       ex_funct7,
   output logic             load_use_stall,
   output logic [CNT_W-1:0] stall_bubbles,
   output logic [CNT_W-1:0] flush_bubbles
);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [2:0]      funct3;
      logic [6:0]      funct7;
   } data_t;

   ctrl_t      id_ctrl, ex_ctrl;
   data_t      id_data, ex_data;
   logic       ex_vld;
   logic       haz;
   logic       bubble;
   logic [CNT_W-1:0] sb_cnt, fb_cnt;

   assign id_ctrl = '{RegWrite:   id_RegWrite,
                      ALUsrc:     id_ALUsrc,
                      PCtoRegSrc: id_PCtoRegSrc,
                      RDsrc:      id_RDsrc,
                      MRead:      id_MRead,
                      MWrite:     id_MWrite,
                      MenToReg:   id_MenToReg,
                      ALUop:      alu_op_e'(id_ALUop),
                      branchCtrl: br_ctrl_e'(id_branchCtrl)};

   assign id_data = '{pc: id_pc, rs1_data: id_rs1_data, rs2_data: id_rs2_data,
                      imm: id_imm, rs1: id_rs1, rs2: id_rs2, rd: id_rd,
                      funct3: id_funct3, funct7: id_funct7};

   hazard_detect u_haz (
      .id_op    (id_op),
      .id_valid (id_valid),
      .id_rs1   (id_rs1),
      .id_rs2   (id_rs2),
      .ex_valid (ex_vld),
      .ex_MRead (ex_ctrl.MRead),
      .ex_rd    (ex_data.rd),
      .haz      (haz)
   );

   // Wrong-path instructions are squashed, so they must not also raise a stall.
   assign load_use_stall = haz && !flush;
   assign bubble         = flush || haz || !id_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_vld  <= 1'b0;
         ex_ctrl <= BUBBLE;
         ex_data <= '0;
         sb_cnt  <= '0;
         fb_cnt  <= '0;
      end else if (!hold) begin
         if (bubble) begin
            ex_vld  <= 1'b0;
            ex_ctrl <= BUBBLE;
            ex_data <= '0;
         end else begin
            ex_vld  <= 1'b1;
            ex_ctrl <= id_ctrl;
            ex_data <= id_data;
         end
         if (flush)    fb_cnt <= fb_cnt + CNT_W'(1);
         else if (haz) sb_cnt <= sb_cnt + CNT_W'(1);
      end
   end

   assign ex_valid      = ex_vld;
   assign ex_RegWrite   = ex_ctrl.RegWrite;
   assign ex_ALUsrc     = ex_ctrl.ALUsrc;
   assign ex_PCtoRegSrc = ex_ctrl.PCtoRegSrc;
   assign ex_RDsrc      = ex_ctrl.RDsrc;
   assign ex_MRead      = ex_ctrl.MRead;
   assign ex_MWrite     = ex_ctrl.MWrite;
   assign ex_MenToReg   = ex_ctrl.MenToReg;
   assign ex_ALUop      = ex_ctrl.ALUop;
   assign ex_branchCtrl = ex_ctrl.branchCtrl;
   assign ex_pc         = ex_data.pc;
   assign ex_rs1_data   = ex_data.rs1_data;
   assign ex_rs2_data   = ex_data.rs2_data;
   assign ex_imm        = ex_data.imm;
   assign ex_rs1        = ex_data.rs1;
   assign ex_rs2        = ex_data.rs2;
   assign ex_rd         = ex_data.rd;
   assign ex_funct3     = ex_data.funct3;
   assign ex_funct7     = ex_data.funct7;
   assign stall_bubbles = sb_cnt;
   assign flush_bubbles = fb_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed + random bench for id_ex_stage against a cycle-level reference
// model of the ID/EX register (narrow counters so wrap is reachable).
module tb_id_ex_stage;
   import riscv_pkg::*;

   localparam int XLEN  = 32;
   localparam int CNT_W = 8;

   typedef struct packed {
      logic RegWrite, ALUsrc, PCtoRegSrc, RDsrc, MRead, MWrite, MenToReg;
      logic [2:0]  ALUop;
      logic [1:0]  branchCtrl;
      logic [31:0] pc, rs1_data, rs2_data, imm;
      logic [4:0]  rs1, rs2, rd;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
   } fields_t;

   logic clk = 1'b0, rst_n = 1'b0, hold = 1'b0, flush = 1'b0, id_valid = 1'b0;
   logic [6:0] id_op = '0;
   fields_t id_f = '0;
   fields_t ex_f;

   logic ex_valid, ex_RegWrite, ex_ALUsrc, ex_PCtoRegSrc, ex_RDsrc, ex_MRead, ex_MWrite, ex_MenToReg;
   logic [2:0] ex_ALUop, ex_funct3;
   logic [1:0] ex_branchCtrl;
   logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
   logic [4:0] ex_rs1, ex_rs2, ex_rd;
   logic [6:0] ex_funct7;
   logic load_use_stall;
   logic [CNT_W-1:0] stall_bubbles, flush_bubbles;

   // reference model state
   fields_t m_ex = '0;
   logic    m_vld = 1'b0;
   int      m_sb = 0, m_fb = 0;
   int      n_chk = 0, n_fail = 0;

   always #5 clk = ~clk;

   id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush), .id_valid(id_valid), .id_op(id_op),
      .id_RegWrite(id_f.RegWrite), .id_ALUsrc(id_f.ALUsrc), .id_PCtoRegSrc(id_f.PCtoRegSrc),
      .id_RDsrc(id_f.RDsrc), .id_MRead(id_f.MRead), .id_MWrite(id_f.MWrite), .id_MenToReg(id_f.MenToReg),
      .id_ALUop(id_f.ALUop), .id_branchCtrl(id_f.branchCtrl), .id_pc(id_f.pc),
      .id_rs1_data(id_f.rs1_data), .id_rs2_data(id_f.rs2_data), .id_imm(id_f.imm),
      .id_rs1(id_f.rs1), .id_rs2(id_f.rs2), .id_rd(id_f.rd), .id_funct3(id_f.funct3), .id_funct7(id_f.funct7),
      .ex_valid(ex_valid), .ex_RegWrite(ex_RegWrite), .ex_ALUsrc(ex_ALUsrc), .ex_PCtoRegSrc(ex_PCtoRegSrc),
      .ex_RDsrc(ex_RDsrc), .ex_MRead(ex_MRead), .ex_MWrite(ex_MWrite), .ex_MenToReg(ex_MenToReg),
      .ex_ALUop(ex_ALUop), .ex_branchCtrl(ex_branchCtrl), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
      .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_funct3(ex_funct3), .ex_funct7(ex_funct7), .load_use_stall(load_use_stall),
      .stall_bubbles(stall_bubbles), .flush_bubbles(flush_bubbles)
   );

   assign ex_f = {ex_RegWrite, ex_ALUsrc, ex_PCtoRegSrc, ex_RDsrc, ex_MRead, ex_MWrite, ex_MenToReg,
                  ex_ALUop, ex_branchCtrl, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
                  ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7};

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic model_haz();
      logic u1, u2;
      u1 = !(id_op inside {OP_LUI, OP_AUIPC, OP_JAL});
      u2 = id_op inside {OP_R, OP_S, OP_B};
      return id_valid && m_vld && m_ex.MRead && (m_ex.rd != 0) &&
             ((u1 && m_ex.rd == id_f.rs1) || (u2 && m_ex.rd == id_f.rs2));
   endfunction

   task automatic chk_state();
      chk("ex_valid", ex_valid, m_vld);
      chk("ex_fields", ex_f, m_ex);
      chk("stall_bubbles", stall_bubbles, m_sb[CNT_W-1:0]);
      chk("flush_bubbles", flush_bubbles, m_fb[CNT_W-1:0]);
   endtask

   task automatic model_reset();
      m_ex = '0; m_vld = 1'b0; m_sb = 0; m_fb = 0;
   endtask

   // One clock: check the combinational stall, predict, clock, compare.
   task automatic step();
      fields_t nx; logic nv; int nsb, nfb; logic h;
      #1;
      h = model_haz();
      chk("load_use_stall", load_use_stall, h && !flush);
      nx = m_ex; nv = m_vld; nsb = m_sb; nfb = m_fb;
      if (!hold) begin
         if (flush)          begin nx = '0; nv = 0; nfb = (m_fb + 1) % (1 << CNT_W); end
         else if (h)         begin nx = '0; nv = 0; nsb = (m_sb + 1) % (1 << CNT_W); end
         else if (!id_valid) begin nx = '0; nv = 0; end
         else                begin nx = id_f; nv = 1; end
      end
      @(posedge clk);
      #1;
      m_ex = nx; m_vld = nv; m_sb = nsb; m_fb = nfb;
      chk_state();
   endtask

   task automatic set_instr(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [31:0] d1, input logic [31:0] d2);
      fields_t f;
      f = '0;
      f.pc = 32'h0000_1000 + 32'(rd) * 4; f.rs1_data = d1; f.rs2_data = d2; f.imm = 32'h10;
      f.rs1 = rs1; f.rs2 = rs2; f.rd = rd;
      case (op)
         OP_R:    f.RegWrite = 1'b1;
         OP_LOAD: begin f.RegWrite = 1; f.ALUsrc = 1; f.MRead = 1; f.MenToReg = 1; f.funct3 = 3'b010; end
         OP_LUI:  begin f.RegWrite = 1; f.ALUsrc = 1; f.RDsrc = 1; end
         OP_JAL:  begin f.RegWrite = 1; f.PCtoRegSrc = 1; f.branchCtrl = 2'd2; end
         default: f.ALUsrc = 1'b1;
      endcase
      id_op = op; id_f = f; id_valid = 1'b1;
   endtask

   initial begin
      logic [6:0] ops [9];
      ops = '{OP_R, OP_S, OP_B, OP_LOAD, OP_IMM, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

      // reset state
      #3;
      chk("reset_valid", ex_valid, 1'b0);
      chk_state();
      @(negedge clk) rst_n = 1'b1;

      // ADD x3,x1,x2 passes through in one cycle
      set_instr(OP_R, 5'd3, 5'd1, 5'd2, 32'd5, 32'd7);
      step();
      chk("add_valid", ex_valid, 1'b1);
      chk("add_regwrite", ex_RegWrite, 1'b1);
      chk("add_aluop", ex_ALUop, 3'b000);
      chk("add_rs1_data", ex_rs1_data, 32'd5);
      chk("add_rd", ex_rd, 5'd3);

      // LW x5 then dependent ADD x6,x5,x1: one bubble, then ADD passes
      set_instr(OP_LOAD, 5'd5, 5'd2, 5'd0, 32'h40, 32'h0);
      step();
      set_instr(OP_R, 5'd6, 5'd5, 5'd1, 32'h9, 32'h3);
      #1 chk("lu_stall_high", load_use_stall, 1'b1);
      step();
      chk("lu_bubble_valid", ex_valid, 1'b0);
      chk("lu_stall_cnt", stall_bubbles, 8'd1);
      step();
      chk("lu_after_valid", ex_valid, 1'b1);
      chk("lu_after_rd", ex_rd, 5'd6);

      // load to x0 never stalls
      set_instr(OP_LOAD, 5'd0, 5'd1, 5'd0, 32'h0, 32'h0);
      step();
      set_instr(OP_R, 5'd7, 5'd0, 5'd0, 32'h0, 32'h0);
      #1 chk("x0_no_stall", load_use_stall, 1'b0);
      step();

      // LUI does not read rs1 even if the field matches
      set_instr(OP_LOAD, 5'd5, 5'd1, 5'd0, 32'h0, 32'h0);
      step();
      set_instr(OP_LUI, 5'd5, 5'd5, 5'd5, 32'h0, 32'h0);
      #1 chk("lui_no_stall", load_use_stall, 1'b0);
      step();

      // flush beats hazard
      set_instr(OP_LOAD, 5'd5, 5'd1, 5'd0, 32'h0, 32'h0);
      step();
      set_instr(OP_R, 5'd6, 5'd5, 5'd1, 32'h1, 32'h2);
      flush = 1'b1;
      #1 chk("flush_no_stall", load_use_stall, 1'b0);
      step();
      chk("flush_cnt", flush_bubbles, 8'd1);
      chk("flush_stall_cnt", stall_bubbles, 8'd1);
      chk("flush_bubble_valid", ex_valid, 1'b0);
      flush = 1'b0;

      // hold freezes a JAL in EX, even against flush
      set_instr(OP_JAL, 5'd1, 5'd0, 5'd0, 32'h0, 32'h0);
      step();
      hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_instr(OP_R, 5'(i + 8), 5'd1, 5'd2, $urandom, $urandom);
         flush = (i == 1);
         step();
      end
      chk("hold_valid", ex_valid, 1'b1);
      chk("hold_rd", ex_rd, 5'd1);
      chk("hold_branch", ex_branchCtrl, 2'd2);
      hold = 1'b0; flush = 1'b0;
      set_instr(OP_R, 5'd9, 5'd1, 5'd2, 32'h11, 32'h22);
      step();
      chk("release_rd", ex_rd, 5'd9);

      // asynchronous reset mid-traffic with a valid instruction in EX
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk("async_rst_valid", ex_valid, 1'b0);
      chk_state();
      #2 rst_n = 1'b1;
      step();

      // stall counter wrap: a load that depends on itself stalls every other cycle
      #1 rst_n = 1'b0;
      #1 rst_n = 1'b1;
      model_reset();
      set_instr(OP_LOAD, 5'd5, 5'd5, 5'd0, 32'h0, 32'h0);
      step();
      for (int i = 0; i < 255; i++) begin
         step();
         step();
      end
      chk("wrap_pre", stall_bubbles, 8'hFF);
      step();
      chk("wrap_zero", stall_bubbles, 8'h00);

      // random traffic with small register indices to provoke hazards
      for (int i = 0; i < 400; i++) begin
         fields_t f;
         f = fields_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
         f.rs1 = 5'($urandom_range(0, 3));
         f.rs2 = 5'($urandom_range(0, 3));
         f.rd  = 5'($urandom_range(0, 3));
         id_f     = f;
         id_op    = ops[$urandom_range(0, 8)];
         id_valid = ($urandom_range(0, 9) < 8);
         hold     = ($urandom_range(0, 9) < 2);
         flush    = ($urandom_range(0, 9) < 1);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
